cpu_run_monitor: RTL and testbench

- Observer that sits beside the single-cycle MIPS TopLevel; it is the CPU-facing end of the run-control path.
- Watches the retired-instruction stream and decodes `syscall` using the MARS register convention ($v0 = service, $a0 = argument).
- Reports halt, exit code, console output and run statistics back to the bench, and enforces a cycle budget (watchdog).
- Replaces the "count clocks and hope syscall happened" approach with an explicit halted/timeout indication.

---
 rtl/cpu_run_monitor.sv | 132 +++++++++++++
 tb/tb_cpu_run_monitor.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_monitor.sv
// Run-control observer for the single-cycle MIPS core: decodes MARS-style syscalls from the
// retired-instruction stream, reports halt/exit/console events and enforces a cycle budget.
module cpu_run_monitor #(
  parameter int unsigned CYCLE_LIMIT = 50000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  input  logic [31:0]      pc,
  input  logic [31:0]      v0,
  input  logic [31:0]      a0,
  output logic             halted,
  output logic             timeout,
  output logic [31:0]      exit_code,
  output logic [31:0]      halt_pc,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count,
  output logic             print_valid,
  output logic [1:0]       print_kind,
  output logic [31:0]      print_data,
  output logic             bad_syscall
);

  typedef enum logic [1:0] {StRun, StHalted, StTimeout} state_e;

  localparam logic [CNT_W-1:0] LimitM1 = CNT_W'(CYCLE_LIMIT - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] icount_q, icount_d;
  logic [31:0]      exit_q, exit_d;
  logic [31:0]      hpc_q, hpc_d;
  logic             pvalid_q, pvalid_d;
  logic [1:0]       pkind_q, pkind_d;
  logic [31:0]      pdata_q, pdata_d;
  logic             bad_q, bad_d;
  logic             is_sys;
  logic             is_exit;

  always_comb begin
    is_sys  = instr_valid && (instr[31:26] == 6'h00) && (instr[5:0] == 6'h0C);
    is_exit = is_sys && ((v0 == 32'd10) || (v0 == 32'd17));

    state_d  = state_q;
    cycle_d  = cycle_q;
    icount_d = icount_q;
    exit_d   = exit_q;
    hpc_d    = hpc_q;
    pvalid_d = 1'b0;
    pkind_d  = pkind_q;
    pdata_d  = pdata_q;
    bad_d    = bad_q;

    if (state_q == StRun) begin
      if (cycle_q != CntMax) cycle_d = cycle_q + CntOne;
      if (instr_valid) begin
        if (icount_q != CntMax) icount_d = icount_q + CntOne;
        hpc_d = pc;
      end
      if (is_sys) begin
        case (v0)
          32'd10: begin
            state_d = StHalted;
            exit_d  = 32'd0;
          end
          32'd17: begin
            state_d = StHalted;
            exit_d  = a0;
          end
          32'd1: begin
            pvalid_d = 1'b1;
            pkind_d  = 2'd0;
            pdata_d  = a0;
          end
          32'd11: begin
            pvalid_d = 1'b1;
            pkind_d  = 2'd1;
            pdata_d  = {24'b0, a0[7:0]};
          end
          32'd4: begin
            pvalid_d = 1'b1;
            pkind_d  = 2'd2;
            pdata_d  = a0;
          end
          default: bad_d = 1'b1;
        endcase
      end
      // An exit in the budget's last cycle takes priority over the timeout.
      if (!is_exit && (cycle_q == LimitM1)) state_d = StTimeout;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StRun;
      cycle_q  <= '0;
      icount_q <= '0;
      exit_q   <= '0;
      hpc_q    <= '0;
      pvalid_q <= 1'b0;
      pkind_q  <= '0;
      pdata_q  <= '0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cycle_q  <= cycle_d;
      icount_q <= icount_d;
      exit_q   <= exit_d;
      hpc_q    <= hpc_d;
      pvalid_q <= pvalid_d;
      pkind_q  <= pkind_d;
      pdata_q  <= pdata_d;
      bad_q    <= bad_d;
    end
  end

  assign halted      = (state_q == StHalted);
  assign timeout     = (state_q == StTimeout);
  assign exit_code   = exit_q;
  assign halt_pc     = hpc_q;
  assign cycle_count = cycle_q;
  assign instr_count = icount_q;
  assign print_valid = pvalid_q;
  assign print_kind  = pkind_q;
  assign print_data  = pdata_q;
  assign bad_syscall = bad_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor: console events go through a scoreboard queue checked by
// a monitor process; status outputs are checked directly after each stimulus cycle.
module tb_cpu_run_monitor;

  localparam logic [31:0] Sys = 32'h0000_000C;
  localparam logic [31:0] Add = 32'h0109_5020;
  localparam logic [31:0] Addi = 32'h2000_000C;  // funct bits match but opcode is not SPECIAL

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0, pc = '0, v0 = '0, a0 = '0;

  logic        halted, timeout, print_valid, bad_syscall;
  logic [31:0] exit_code, halt_pc, print_data, cycle_count, instr_count;
  logic [1:0]  print_kind;

  logic        t_halted, t_timeout, t_print_valid, t_bad_syscall;
  logic [31:0] t_exit_code, t_halt_pc, t_print_data, t_cycle_count, t_instr_count;
  logic [1:0]  t_print_kind;

  int n_checks = 0;
  int n_fail = 0;
  logic [33:0] exp_q[$];  // {kind, data}

  always #5 clock = ~clock;

  cpu_run_monitor #(.CYCLE_LIMIT(1000), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr(instr), .pc(pc),
    .v0(v0), .a0(a0), .halted(halted), .timeout(timeout), .exit_code(exit_code),
    .halt_pc(halt_pc), .cycle_count(cycle_count), .instr_count(instr_count),
    .print_valid(print_valid), .print_kind(print_kind), .print_data(print_data),
    .bad_syscall(bad_syscall)
  );

  cpu_run_monitor #(.CYCLE_LIMIT(8), .CNT_W(32)) dut_t (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr(instr), .pc(pc),
    .v0(v0), .a0(a0), .halted(t_halted), .timeout(t_timeout), .exit_code(t_exit_code),
    .halt_pc(t_halt_pc), .cycle_count(t_cycle_count), .instr_count(t_instr_count),
    .print_valid(t_print_valid), .print_kind(t_print_kind), .print_data(t_print_data),
    .bad_syscall(t_bad_syscall)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] i, input logic [31:0] p,
                      input logic [31:0] r2, input logic [31:0] r4);
    instr_valid = v;
    instr = i;
    pc = p;
    v0 = r2;
    a0 = r4;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0, '0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
  endtask

  // Scoreboard monitor: every print pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    if (!reset && print_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL print_unexpected: got kind %0d data %h expected no event",
                 print_kind, print_data);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        if ({print_kind, print_data} !== e) begin
          n_fail++;
          $display("FAIL print_event: got kind %0d data %h expected kind %0d data %h",
                   print_kind, print_data, e[33:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    logic [31:0] cc, ic;

    // Reset state
    do_reset();
    check("rst_cycle", cycle_count, 32'd0);
    check("rst_flags", {28'd0, halted, timeout, bad_syscall, print_valid}, 32'd0);
    check("rst_exit_pc", exit_code | halt_pc, 32'd0);

    // Idle counting
    idle(3);
    check("idle_cycle", cycle_count, 32'd3);
    check("idle_instr", instr_count, 32'd0);
    check("idle_flags", {29'd0, halted, timeout, bad_syscall}, 32'd0);

    // Print int
    for (int k = 0; k < 5; k++) step(1'b1, Add, 32'h0040_0000 + 32'(4 * k), 32'd1, 32'd7);
    exp_q.push_back({2'd0, 32'hFFFF_FFF6});
    step(1'b1, Sys, 32'h0040_0014, 32'd1, 32'hFFFF_FFF6);
    check("int_pulse", {31'd0, print_valid}, 32'd1);
    check("int_icount", instr_count, 32'd6);
    check("int_cycle", cycle_count, 32'd9);
    idle(1);
    check("int_pulse_end", {31'd0, print_valid}, 32'd0);
    check("int_data_hold", print_data, 32'hFFFF_FFF6);

    // Print char and string
    exp_q.push_back({2'd1, 32'h0000_0041});
    step(1'b1, Sys, 32'h0040_0018, 32'd11, 32'h1234_5641);
    exp_q.push_back({2'd2, 32'h1001_0000});
    step(1'b1, Sys, 32'h0040_001C, 32'd4, 32'h1001_0000);
    check("str_kind", {30'd0, print_kind}, 32'd2);

    // Exit 17 with code, then frozen
    step(1'b1, Sys, 32'h0040_0020, 32'd17, 32'd42);
    check("exit_halted", {30'd0, halted, timeout}, 32'd2);
    check("exit_code", exit_code, 32'd42);
    check("exit_pc", halt_pc, 32'h0040_0020);
    cc = cycle_count;
    ic = instr_count;
    check("exit_icount", ic, 32'd9);
    step(1'b1, Add, 32'h0040_0024, 32'd1, 32'd5);
    step(1'b1, Sys, 32'h0040_0028, 32'd1, 32'd5);  // print must not fire once halted
    step(1'b1, Sys, 32'h0040_002C, 32'd99, 32'd5);
    check("frozen_cycle", cycle_count, cc);
    check("frozen_icount", instr_count, ic);
    check("frozen_pc", halt_pc, 32'h0040_0020);
    check("frozen_bad", {31'd0, bad_syscall}, 32'd0);

    // Reset while halted
    do_reset();
    check("rst2_flags", {29'd0, halted, timeout, bad_syscall}, 32'd0);
    check("rst2_exit", exit_code, 32'd0);
    idle(2);
    check("rst2_cycle", cycle_count, 32'd2);

    // Unsupported service, then exit 10
    step(1'b1, Addi, 32'h0040_0000, 32'd99, 32'd0);
    check("addi_not_sys", {31'd0, bad_syscall}, 32'd0);
    step(1'b1, Sys, 32'h0040_0004, 32'd99, 32'd3);
    check("bad_set", {31'd0, bad_syscall}, 32'd1);
    step(1'b1, Add, 32'h0040_0008, 32'd1, 32'd3);
    check("bad_sticky", {31'd0, bad_syscall}, 32'd1);
    step(1'b1, Sys, 32'h0040_000C, 32'd10, 32'd77);
    check("exit10_flags", {29'd0, halted, timeout, bad_syscall}, 32'd5);
    check("exit10_code", exit_code, 32'd0);
    check("exit10_pc", halt_pc, 32'h0040_000C);

    // Timeout with CYCLE_LIMIT = 8
    do_reset();
    idle(2);
    step(1'b1, Add, 32'h0040_0100, 32'd0, 32'd0);
    idle(4);
    check("to_pre", {30'd0, t_halted, t_timeout}, 32'd0);
    check("to_pre_cycle", t_cycle_count, 32'd7);
    idle(1);
    check("to_flags", {30'd0, t_halted, t_timeout}, 32'd1);
    check("to_cycle", t_cycle_count, 32'd8);
    check("to_pc", t_halt_pc, 32'h0040_0100);
    step(1'b1, Add, 32'h0040_0200, 32'd0, 32'd0);
    idle(1);
    check("to_frozen_cycle", t_cycle_count, 32'd8);
    check("to_frozen_icount", t_instr_count, 32'd1);
    check("to_frozen_pc", t_halt_pc, 32'h0040_0100);

    // Exit in the last budget cycle beats the timeout
    do_reset();
    idle(7);
    step(1'b1, Sys, 32'h0040_0300, 32'd10, 32'd0);
    check("race_flags", {30'd0, t_halted, t_timeout}, 32'd2);
    check("race_cycle", t_cycle_count, 32'd8);
    check("race_pc", t_halt_pc, 32'h0040_0300);
    idle(2);
    check("race_hold", {30'd0, t_halted, t_timeout}, 32'd2);

    idle(2);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
